// File: rtl/operand_stream_feeder.sv
// Operand feeder: buffers paired A/B beats and presents one job of exactly len
// beats to the systolic core, with len_input held stable for the whole job.
module operand_stream_feeder #(
    parameter int DATA_WIDTH   = 8,
    parameter int N            = 4,
    parameter int COUNTER_BITS = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [COUNTER_BITS-1:0]          cmd_len,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [N-1:0][DATA_WIDTH-1:0]     s_a_data,
    input  logic [N-1:0][DATA_WIDTH-1:0]     s_b_data,
    output logic                             a_input_valid,
    output logic                             b_input_valid,
    input  logic                             input_ready,
    output logic [COUNTER_BITS-1:0]          len_input,
    output logic [N-1:0][DATA_WIDTH-1:0]     a_data,
    output logic [N-1:0][DATA_WIDTH-1:0]     b_data,
    output logic                             busy,
    output logic                             job_done
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t                        r_state, w_next;
    logic [COUNTER_BITS-1:0]       r_len, r_recv_cnt, r_sent_cnt;
    logic [AW:0]                   r_wptr, r_rptr;
    logic [N-1:0][DATA_WIDTH-1:0]  r_mem_a [FIFO_DEPTH];
    logic [N-1:0][DATA_WIDTH-1:0]  r_mem_b [FIFO_DEPTH];

    logic w_full, w_empty, w_valid, w_push, w_pop, w_last, w_cmd_fire;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_empty    = (r_wptr == r_rptr);
    assign w_valid    = (r_state == STREAM) && !w_empty;
    assign s_ready    = (r_state == STREAM) && !w_full && (r_recv_cnt < r_len);
    assign w_push     = s_valid && s_ready;
    assign w_pop      = w_valid && input_ready;
    assign w_last     = w_pop && (r_sent_cnt == r_len - COUNTER_BITS'(1));
    assign w_cmd_fire = cmd_valid && (r_state == IDLE);

    assign a_input_valid = w_valid;
    assign b_input_valid = w_valid;
    assign len_input     = r_len;
    assign a_data        = w_valid ? r_mem_a[r_rptr[AW-1:0]] : '0;
    assign b_data        = w_valid ? r_mem_b[r_rptr[AW-1:0]] : '0;

    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        job_done  = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) w_next = (cmd_len == '0) ? DONE : STREAM;
            end
            STREAM: if (w_last) w_next = DONE;
            DONE: begin
                job_done = 1'b1;
                w_next   = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_len      <= '0;
            r_recv_cnt <= '0;
            r_sent_cnt <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
        end else begin
            r_state <= w_next;
            if (w_cmd_fire) begin
                r_len      <= cmd_len;
                r_recv_cnt <= '0;
                r_sent_cnt <= '0;
            end else begin
                if (w_push) begin
                    r_recv_cnt <= r_recv_cnt + COUNTER_BITS'(1);
                    r_wptr     <= r_wptr + 1'b1;
                end
                if (w_pop) begin
                    r_sent_cnt <= r_sent_cnt + COUNTER_BITS'(1);
                    r_rptr     <= r_rptr + 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: the head is masked to zero while empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wptr[AW-1:0]] <= s_a_data;
            r_mem_b[r_wptr[AW-1:0]] <= s_b_data;
        end
    end
endmodule

// File: tb/tb_operand_stream_feeder.sv
// Bench for operand_stream_feeder: queue-based job model checked every cycle,
// plus directed jobs with literal expectations on order, counts and timing.
module tb_operand_stream_feeder;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
    } beat_t;

    logic             clk, reset, cmd_valid, cmd_ready, s_valid, s_ready;
    logic [15:0]      cmd_len, len_input;
    logic [3:0][7:0]  s_a_data, s_b_data, a_data, b_data;
    logic             a_input_valid, b_input_valid, input_ready, busy, job_done;

    operand_stream_feeder dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_len(cmd_len), .s_valid(s_valid), .s_ready(s_ready),
        .s_a_data(s_a_data), .s_b_data(s_b_data),
        .a_input_valid(a_input_valid), .b_input_valid(b_input_valid),
        .input_ready(input_ready), .len_input(len_input),
        .a_data(a_data), .b_data(b_data), .busy(busy), .job_done(job_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0;
    int cyc = 0, cmd_acc = 0, acc_cnt = 0, done_seen = 0, acc_cyc = 0, last_done_cyc = 0;
    bit src_pop = 0;
    beat_t src[$], mq[$], xlog[$];

    // Model: phase 0 idle, 1 streaming, 2 done pulse.
    int m_phase = 0, m_recv = 0, m_sent = 0;
    logic [15:0] m_len = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    function automatic beat_t mk(input int a, input int b);
        beat_t r;
        r.a = {4{a[7:0]}};
        r.b = {4{b[7:0]}};
        return r;
    endfunction

    always @(negedge clk) begin
        logic e_sready, e_valid;
        logic [31:0] e_a, e_b;
        cyc++;
        if (!reset) begin
            m_phase = 0; m_len = 0; m_recv = 0; m_sent = 0;
            mq.delete();
        end
        e_sready = (m_phase == 1) && (mq.size() < DEPTH) && (m_recv < int'(m_len));
        e_valid  = (m_phase == 1) && (mq.size() > 0);
        e_a = e_valid ? mq[0].a : 32'h0;
        e_b = e_valid ? mq[0].b : 32'h0;
        chk("cmd_ready", cmd_ready, m_phase == 0);
        chk("s_ready", s_ready, e_sready);
        chk("a_valid", a_input_valid, e_valid);
        chk("b_valid", b_input_valid, e_valid);
        chk("a_data", a_data, e_a);
        chk("b_data", b_data, e_b);
        chk("len_input", len_input, m_len);
        chk("busy", busy, m_phase != 0);
        chk("job_done", job_done, m_phase == 2);

        if (a_input_valid && input_ready) xlog.push_back('{a: a_data, b: b_data});
        if (job_done) begin done_seen++; last_done_cyc = cyc; end
        if (cmd_valid && cmd_ready && reset) begin cmd_acc++; acc_cyc = cyc; end
        if (s_valid && s_ready) acc_cnt++;
        src_pop = s_valid && s_ready && reset;

        if (reset) begin
            case (m_phase)
                0: if (cmd_valid) begin
                    m_len = cmd_len; m_recv = 0; m_sent = 0;
                    m_phase = (cmd_len == 0) ? 2 : 1;
                end
                1: begin
                    if (e_valid && input_ready) begin
                        void'(mq.pop_front());
                        m_sent++;
                        if (m_sent == int'(m_len)) m_phase = 2;
                    end
                    if (s_valid && e_sready) begin
                        mq.push_back('{a: s_a_data, b: s_b_data});
                        m_recv++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    // Upstream source: offers the head of src, drops it after a handshake.
    initial begin
        s_valid = 0; s_a_data = '0; s_b_data = '0;
        forever begin
            @(posedge clk);
            if (src_pop && src.size() > 0) void'(src.pop_front());
            #1;
            s_valid  = src.size() > 0;
            s_a_data = (src.size() > 0) ? src[0].a : '0;
            s_b_data = (src.size() > 0) ? src[0].b : '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_job(input int len);
        int a0 = cmd_acc;
        cmd_valid = 1; cmd_len = 16'(len);
        for (int i = 0; i < 20 && cmd_acc == a0; i++) tick();
        cmd_valid = 0;
        chk("cmd_accept", cmd_acc - a0, 1);
    endtask

    task automatic wait_done();
        int d0 = done_seen;
        for (int i = 0; i < 200 && done_seen == d0; i++) tick();
        chk("job_done_seen", done_seen - d0, 1);
        tick();
    endtask

    task automatic chk_log(input string name, input int base, input int n, input int a0, input int b0);
        chk(name, xlog.size() - base, n);
        for (int i = 0; i < n && base + i < xlog.size(); i++) begin
            chk(name, xlog[base+i].a, mk(a0 + i, b0 + i).a);
            chk(name, xlog[base+i].b, mk(a0 + i, b0 + i).b);
        end
    endtask

    initial begin
        int base, acc0, d0, a0;
        reset = 0; cmd_valid = 0; cmd_len = 0; input_ready = 0;
        repeat (3) tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_valid", a_input_valid, 0);
        chk("rst_len", len_input, 0);
        chk("rst_busy", busy, 0);
        reset = 1;
        tick();

        // Basic 3-beat job, core always ready
        for (int i = 0; i < 3; i++) src.push_back(mk(1 + i, 4 + i));
        input_ready = 1; base = xlog.size(); d0 = done_seen;
        run_job(3);
        chk("t1_len_input", len_input, 3);
        wait_done();
        chk_log("t1_order", base, 3, 1, 4);
        chk("t1_done_once", done_seen - d0, 1);

        // Backpressure: FIFO fills at 4, head holds
        for (int i = 0; i < 5; i++) src.push_back(mk(10 + i, 20 + i));
        input_ready = 0; base = xlog.size(); acc0 = acc_cnt;
        run_job(5);
        repeat (8) tick();
        chk("t2_accepted_full", acc_cnt - acc0, 4);
        chk("t2_head_hold", a_data, mk(10, 20).a);
        chk("t2_valid_hold", a_input_valid, 1);
        input_ready = 1;
        wait_done();
        chk_log("t2_order", base, 5, 10, 20);

        // Zero-length job
        src.push_back(mk(90, 91)); src.push_back(mk(92, 93));
        base = xlog.size(); acc0 = acc_cnt;
        run_job(0);
        wait_done();
        chk("t3_no_accept", acc_cnt - acc0, 0);
        chk("t3_no_xfer", xlog.size() - base, 0);
        src.delete();
        tick();

        // Upstream over-offers
        for (int i = 0; i < 8; i++) src.push_back(mk(30 + i, 40 + i));
        base = xlog.size(); acc0 = acc_cnt;
        run_job(3);
        wait_done();
        chk("t4_accepted", acc_cnt - acc0, 3);
        chk_log("t4_order", base, 3, 30, 40);
        src.delete();
        tick();

        // Reset mid-job
        for (int i = 0; i < 4; i++) src.push_back(mk(50 + i, 60 + i));
        base = xlog.size(); d0 = done_seen;
        run_job(4);
        for (int i = 0; i < 50 && xlog.size() - base < 2; i++) tick();
        #1 reset = 0;
        #1;
        chk("mid_rst_valid", a_input_valid, 0);
        chk("mid_rst_bvalid", b_input_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 1);
        chk("mid_rst_s_ready", s_ready, 0);
        chk("mid_rst_len", len_input, 0);
        chk("mid_rst_a_data", a_data, 0);
        src.delete();
        tick();
        reset = 1;
        tick();
        chk("mid_rst_no_done", done_seen - d0, 0);
        src.push_back(mk(60, 70)); src.push_back(mk(61, 71));
        base = xlog.size();
        run_job(2);
        chk("t5_len_input", len_input, 2);
        wait_done();
        chk_log("t5_order", base, 2, 60, 70);

        // Back-to-back jobs with cmd_valid held
        for (int i = 0; i < 5; i++) src.push_back(mk(80 + i, 100 + i));
        base = xlog.size(); a0 = cmd_acc;
        cmd_valid = 1; cmd_len = 2;
        for (int i = 0; i < 20 && cmd_acc == a0; i++) tick();
        cmd_len = 3;
        for (int i = 0; i < 200 && cmd_acc < a0 + 2; i++) tick();
        cmd_valid = 0;
        chk("t6_two_accepts", cmd_acc - a0, 2);
        chk("t6_gap_after_done", acc_cyc - last_done_cyc, 1);
        chk("t6_len_input", len_input, 3);
        wait_done();
        chk_log("t6_order", base, 5, 80, 100);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
